// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// Optional watchdog on the transmitter handshake: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arb_enable,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [2:0]           grant_id,
  output logic                 arb_busy,
  input  logic                 Tx_BUSY,
  output logic [7:0]           Tx_DATA,
  output logic                 Tx_WR,
  output logic                 Tx_EN
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("uart_tx_arbiter: unsupported parameter value");
  end

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StWrite,
    StWaitHi,
    StWaitLo
  } state_e;

  state_e     state_q;
  logic [2:0] cand;
  logic [2:0] winner;
  logic [7:0] winner_data;
  logic       timeout_hit;

  // grant_id doubles as the round-robin pointer. Scan from farthest to nearest
  // so the last match is the first requester after the pointer.
  always_comb begin
    cand   = '0;
    winner = grant_id;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      cand = 3'((32'(grant_id) + k) % NUM_REQ);
      if (|(req & (NUM_REQ'(1) << cand))) begin
        winner = cand;
      end
    end
    winner_data = 8'(req_data >> {winner, 3'b000});
  end

  assign arb_busy = (state_q != StIdle);

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [31:0] cnt_q;
  logic        in_wait;
  logic        wait_exit;

  assign in_wait     = (state_q == StWaitHi) || (state_q == StWaitLo);
  assign wait_exit   = ((state_q == StWaitHi) && Tx_BUSY) || ((state_q == StWaitLo) && !Tx_BUSY);
  assign timeout_hit = in_wait && !wait_exit && (cnt_q == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (in_wait && !wait_exit && !timeout_hit) begin
        cnt_q <= cnt_q + 32'd1;
      end else begin
        cnt_q <= '0;
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      grant_id <= 3'(NUM_REQ - 1);
      ack      <= '0;
      Tx_DATA  <= 8'h00;
      Tx_WR    <= 1'b0;
      Tx_EN    <= 1'b0;
    end else begin
      ack   <= '0;
      Tx_WR <= 1'b0;
      Tx_EN <= arb_enable;
      case (state_q)
        StIdle: begin
          if (arb_enable && |req && !Tx_BUSY) begin
            state_q <= StGrant;
          end
        end
        StGrant: begin
          Tx_DATA  <= winner_data;
          grant_id <= winner;
          Tx_WR    <= 1'b1;
          Tx_EN    <= 1'b1;
          state_q  <= StWrite;
        end
        StWrite: begin
          Tx_EN   <= 1'b1;
          state_q <= StWaitHi;
        end
        StWaitHi: begin
          if (Tx_BUSY) begin
            Tx_EN   <= 1'b1;
            state_q <= StWaitLo;
          end else if (timeout_hit) begin
            state_q <= StIdle;
          end else begin
            Tx_EN <= 1'b1;
          end
        end
        StWaitLo: begin
          if (!Tx_BUSY) begin
            ack     <= NUM_REQ'(1) << grant_id;
            state_q <= StIdle;
          end else if (timeout_hit) begin
            state_q <= StIdle;
          end else begin
            Tx_EN <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table-driven frames plus hand-written corner sequences,
// with a scoreboard of expected frames and acks checked by a negedge monitor.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        arb_enable;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [2:0]  grant_id;
  logic        arb_busy;
  logic        Tx_BUSY;
  logic [7:0]  Tx_DATA;
  logic        Tx_WR;
  logic        Tx_EN;
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic        timeout_err;
`endif

  uart_tx_arbiter #(
    .NUM_REQ     (4),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .arb_enable (arb_enable),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .grant_id   (grant_id),
    .arb_busy   (arb_busy),
    .Tx_BUSY    (Tx_BUSY),
    .Tx_DATA    (Tx_DATA),
    .Tx_WR      (Tx_WR),
    .Tx_EN      (Tx_EN)
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] id;
    logic [7:0] data;
  } frame_t;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [2:0]  id;
    logic [7:0]  exp;
  } vec_t;

  frame_t     fq[$];
  logic [2:0] aq[$];
  int         total = 0;
  int         bad = 0;
  int         wr_count = 0;
  bit         model_on = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // Transmitter model: busy rises two cycles after the write strobe, stays four cycles.
  initial begin
    Tx_BUSY = 1'b0;
    forever begin
      @(negedge clk);
      if (Tx_WR && model_on) begin
        repeat (2) @(negedge clk);
        Tx_BUSY = 1'b1;
        repeat (4) @(negedge clk);
        Tx_BUSY = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    logic [3:0] ack_prev;
    frame_t     f;
    logic [2:0] id;
    ack_prev = '0;
    forever begin
      @(negedge clk);
      if (Tx_WR) begin
        wr_count++;
        if (fq.size() == 0) begin
          fail_now("unexpected_tx_wr");
        end else begin
          f = fq.pop_front();
          check("tx_data", 32'(Tx_DATA), 32'(f.data));
          check("grant_id", 32'(grant_id), 32'(f.id));
        end
      end
      if (ack != 0) begin
        if (aq.size() == 0) begin
          fail_now("unexpected_ack");
        end else begin
          id = aq.pop_front();
          check("ack_onehot", 32'(ack), 32'(4'b0001 << id));
        end
      end
      if (ack_prev != 0) check("ack_pulse", 32'(ack), 32'h0);
      ack_prev = ack;
    end
  end

  task automatic wait_ack();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 0 && n < 200);
    if (ack == 0) fail_now("ack_wait_timeout");
  endtask

  task automatic wait_wr();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!Tx_WR && n < 50);
    if (!Tx_WR) fail_now("tx_wr_wait_timeout");
  endtask

  task automatic run_frame(input logic [3:0] r, input logic [31:0] d,
                           input logic [2:0] id, input logic [7:0] dat);
    fq.push_back('{id: id, data: dat});
    aq.push_back(id);
    req_data = d;
    req      = r;
    @(negedge clk);
    check("lat_grant_no_wr", 32'(Tx_WR), 32'h0);
    @(negedge clk);
    check("lat_wr", 32'(Tx_WR), 32'h1);
    wait_ack();
    req = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ack"}, 32'(ack), 32'h0);
    check({tag, "_grant_id"}, 32'(grant_id), 32'h3);
    check({tag, "_arb_busy"}, 32'(arb_busy), 32'h0);
    check({tag, "_tx_data"}, 32'(Tx_DATA), 32'h0);
    check({tag, "_tx_wr"}, 32'(Tx_WR), 32'h0);
    check({tag, "_tx_en"}, 32'(Tx_EN), 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_watchdog");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vec_t vt[8];
    int   w0;
    vt[0] = '{req: 4'b0100, data: 32'h00A5_0000, id: 3'd2, exp: 8'hA5};
    vt[1] = '{req: 4'b1111, data: 32'h1312_1110, id: 3'd3, exp: 8'h13};
    vt[2] = '{req: 4'b0011, data: 32'h0000_2120, id: 3'd0, exp: 8'h20};
    vt[3] = '{req: 4'b0011, data: 32'h0000_2120, id: 3'd1, exp: 8'h21};
    vt[4] = '{req: 4'b0011, data: 32'h0000_2120, id: 3'd0, exp: 8'h20};
    vt[5] = '{req: 4'b1000, data: 32'h7E00_0000, id: 3'd3, exp: 8'h7E};
    vt[6] = '{req: 4'b1001, data: 32'h0000_0055, id: 3'd0, exp: 8'h55};
    vt[7] = '{req: 4'b0110, data: 32'h0000_6600, id: 3'd1, exp: 8'h66};

    reset      = 1'b1;
    arb_enable = 1'b1;
    req        = '0;
    req_data   = '0;
    #2 reset = 1'b0;
    #1 check_reset_vals("rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_frame(vt[i].req, vt[i].data, vt[i].id, vt[i].exp);
    end

    // Continuous requesters from reset are served 0,1,2,3,0.
    do_reset();
    req_data = 32'h1312_1110;
    for (int i = 0; i < 5; i++) begin
      fq.push_back('{id: 3'(i % 4), data: 8'(8'h10 + (i % 4))});
      aq.push_back(3'(i % 4));
    end
    req = 4'b1111;
    for (int i = 0; i < 5; i++) wait_ack();
    req = '0;

    // Disable during WAIT_LO: frame still acked, no new writes while disabled.
    fq.push_back('{id: 3'd2, data: 8'h12});
    aq.push_back(3'd2);
    req = 4'b0100;
    wait_wr();
    repeat (4) @(negedge clk);
    arb_enable = 1'b0;
    @(negedge clk);
    check("dis_tx_en_held", 32'(Tx_EN), 32'h1);
    wait_ack();
    check("dis_tx_en_low", 32'(Tx_EN), 32'h0);
    w0 = wr_count;
    repeat (20) @(negedge clk);
    check("dis_no_wr", 32'(wr_count), 32'(w0));
    check("dis_idle", 32'(arb_busy), 32'h0);
    fq.push_back('{id: 3'd2, data: 8'h12});
    aq.push_back(3'd2);
    arb_enable = 1'b1;
    wait_ack();
    req = '0;

    // Reset during WAIT_HI: outputs return to reset values at once, no ack.
    fq.push_back('{id: 3'd0, data: 8'h10});
    req = 4'b0001;
    wait_wr();
    @(negedge clk);
    check("mid_busy_before", 32'(arb_busy), 32'h1);
    reset = 1'b0;
    #1 check_reset_vals("mid");
    req = '0;
    repeat (10) @(negedge clk);
    check("mid_no_ack", 32'(ack), 32'h0);
    reset = 1'b1;
    @(negedge clk);

`ifdef UART_TX_ARB_TIMEOUT_EN
    begin
      int n = 0;
      model_on = 1'b0;
      fq.push_back('{id: 3'd0, data: 8'h10});
      req = 4'b0001;
      wait_wr();
      do begin
        @(negedge clk);
        n++;
      end while (!timeout_err && n < 100);
      req = '0;
      check("to_err", 32'(timeout_err), 32'h1);
      check("to_idle", 32'(arb_busy), 32'h0);
      repeat (5) @(negedge clk);
      check("to_sticky", 32'(timeout_err), 32'h1);
      model_on = 1'b1;
    end
`endif

    repeat (3) @(negedge clk);
    check("frames_left", 32'(fq.size()), 32'h0);
    check("acks_left", 32'(aq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
